// File: rtl/game_controller_pkg.sv
// Shared Pong definitions: match states, winner codes, score width
// and the active video area used by the paddle and ball blocks.
package game_controller_pkg;

   localparam int SCORE_W  = 4;
   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SERVE = 3'd1;
   localparam logic [2:0] ST_PLAY  = 3'd2;
   localparam logic [2:0] ST_POINT = 3'd3;
   localparam logic [2:0] ST_OVER  = 3'd4;

   localparam logic [1:0] WIN_NONE  = 2'b00;
   localparam logic [1:0] WIN_LEFT  = 2'b01;
   localparam logic [1:0] WIN_RIGHT = 2'b10;

   typedef logic [SCORE_W-1:0] score_t;

endpackage

// File: rtl/game_controller_btn_debounce.sv
// Active-low button: 2-FF synchronizer plus consecutive-low counter,
// emitting a single-tick pulse per press.
module btn_debounce #(
   parameter int DEBOUNCE = 20
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic btn_n_i,
   output logic pulse_o
);

   localparam int CW = $clog2(DEBOUNCE + 1);

   logic          sync1_q, sync2_q;
   logic          armed_q, armed_d;
   logic          pulse_q, pulse_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d   = cnt_q;
      armed_d = armed_q;
      pulse_d = 1'b0;
      if (sync2_q) begin
         cnt_d   = '0;
         armed_d = 1'b1;
      end else if (armed_q) begin
         // Disarm after firing so a held button yields one pulse
         if (cnt_q == CW'(DEBOUNCE - 1)) begin
            pulse_d = 1'b1;
            armed_d = 1'b0;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         armed_q <= 1'b0;
         pulse_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_n_i;
         sync2_q <= sync1_q;
         armed_q <= armed_d;
         pulse_q <= pulse_d;
         cnt_q   <= cnt_d;
      end
   end

   assign pulse_o = pulse_q;

endmodule

// File: rtl/game_controller.sv
// Pong match sequencer: start, serve countdown, rally, scoring, game over.
// Sole source of the paddle reset; gates ball motion.
module game_controller
   import game_controller_pkg::*;
#(
   parameter int WIN_SCORE   = 7,
   parameter int SERVE_DELAY = 1000,
   parameter int DEBOUNCE    = 20
) (
   input  logic               clk_1ms,
   input  logic               reset,
   input  logic               start_btn,
   input  logic               miss_left,
   input  logic               miss_right,
   output logic               paddle_rst_n,
   output logic               ball_en,
   output logic               serve_dir,
   output logic [SCORE_W-1:0] score1,
   output logic [SCORE_W-1:0] score2,
   output logic [2:0]         state,
   output logic [1:0]         winner
);

   localparam int            CW         = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
   localparam logic [CW-1:0] SERVE_LOAD = CW'(SERVE_DELAY - 1);
   localparam score_t        WIN        = SCORE_W'(WIN_SCORE);

   logic          start_pulse;
   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   score_t        score1_q, score1_d;
   score_t        score2_q, score2_d;
   logic [1:0]    winner_q, winner_d;
   logic          dir_q, dir_d;

   btn_debounce #(
      .DEBOUNCE (DEBOUNCE)
   ) u_deb (
      .clk_i   (clk_1ms),
      .rst_i   (reset),
      .btn_n_i (start_btn),
      .pulse_o (start_pulse)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      score1_d = score1_q;
      score2_d = score2_q;
      winner_d = winner_q;
      dir_d    = dir_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start_pulse) begin
               state_d = ST_SERVE;
               cnt_d   = SERVE_LOAD;
            end
         end
         ST_SERVE: begin
            if (cnt_q == '0) state_d = ST_PLAY;
            else             cnt_d   = cnt_q - CW'(1);
         end
         ST_PLAY: begin
            // A double miss is a replay: nobody scores
            if (miss_left && miss_right) begin
               state_d = ST_SERVE;
               cnt_d   = SERVE_LOAD;
            end else if (miss_left) begin
               score2_d = score2_q + SCORE_W'(1);
               dir_d    = 1'b0;
               state_d  = ST_POINT;
            end else if (miss_right) begin
               score1_d = score1_q + SCORE_W'(1);
               dir_d    = 1'b1;
               state_d  = ST_POINT;
            end
         end
         ST_POINT: begin
            if (score1_q == WIN) begin
               winner_d = WIN_LEFT;
               state_d  = ST_OVER;
            end else if (score2_q == WIN) begin
               winner_d = WIN_RIGHT;
               state_d  = ST_OVER;
            end else begin
               state_d = ST_SERVE;
               cnt_d   = SERVE_LOAD;
            end
         end
         ST_OVER: begin
            if (start_pulse) begin
               score1_d = '0;
               score2_d = '0;
               winner_d = WIN_NONE;
               dir_d    = 1'b0;
               state_d  = ST_SERVE;
               cnt_d    = SERVE_LOAD;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_1ms or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         score1_q <= '0;
         score2_q <= '0;
         winner_q <= WIN_NONE;
         dir_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         score1_q <= score1_d;
         score2_q <= score2_d;
         winner_q <= winner_d;
         dir_q    <= dir_d;
      end
   end

   assign paddle_rst_n = (state_q == ST_PLAY) || (state_q == ST_POINT);
   assign ball_en      = (state_q == ST_PLAY);
   assign serve_dir    = dir_q;
   assign score1       = score1_q;
   assign score2       = score2_q;
   assign state        = state_q;
   assign winner       = winner_q;

endmodule

// File: tb/tb_game_controller.sv
// Scoreboard bench for game_controller: expected output snapshots are
// queued with the stimulus and compared on the falling clock edge.
module tb_game_controller;

   logic       clk_1ms = 1'b0;
   logic       reset, start_btn, miss_left, miss_right;
   logic       paddle_rst_n, ball_en, serve_dir;
   logic [3:0] score1, score2;
   logic [2:0] state;
   logic [1:0] winner;

   typedef struct {
      string       tag;
      logic [15:0] v;
   } sb_t;

   sb_t sb[$];
   sb_t e;
   int  n_cmp     = 0;
   int  n_bad     = 0;
   int  pulse_cnt = 0;

   game_controller #(
      .WIN_SCORE   (3),
      .SERVE_DELAY (4),
      .DEBOUNCE    (3)
   ) dut (
      .clk_1ms      (clk_1ms),
      .reset        (reset),
      .start_btn    (start_btn),
      .miss_left    (miss_left),
      .miss_right   (miss_right),
      .paddle_rst_n (paddle_rst_n),
      .ball_en      (ball_en),
      .serve_dir    (serve_dir),
      .score1       (score1),
      .score2       (score2),
      .state        (state),
      .winner       (winner)
   );

   always #5 clk_1ms = ~clk_1ms;

   // {state, winner, score1, score2, serve_dir, ball_en, paddle_rst_n}
   function automatic logic [15:0] mk(input int st, input int win,
                                      input int s1, input int s2,
                                      input int dir, input int be,
                                      input int pr);
      return {3'(st), 2'(win), 4'(s1), 4'(s2), 1'(dir), 1'(be), 1'(pr)};
   endfunction

   function automatic logic [15:0] obs();
      return {state, winner, score1, score2, serve_dir, ball_en, paddle_rst_n};
   endfunction

   task automatic chk(input string tag, input logic [15:0] got,
                      input logic [15:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   task automatic push(input string tag, input logic [15:0] v);
      sb_t it;
      it.tag = tag;
      it.v   = v;
      sb.push_back(it);
   endtask

   task automatic tick();
      @(posedge clk_1ms);
      #2;
   endtask

   always @(negedge clk_1ms) begin
      if (dut.start_pulse === 1'b1) pulse_cnt++;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         chk(e.tag, obs(), e.v);
      end
   end

   task automatic serve_to_play(input int n, input logic [15:0] vs,
                                input logic [15:0] vp, input int miss_clr);
      for (int i = 1; i <= n; i++) begin
         tick();
         push("serve", vs);
         if (i == miss_clr) miss_left = 1'b0;
      end
      tick();
      push("play", vp);
   endtask

   task automatic start_match(input logic [15:0] hold);
      int p0;
      p0 = pulse_cnt;
      start_btn = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         tick();
         push("press_wait", hold);
         if (i == 4) chk("pulse_early", 16'(dut.start_pulse), 16'd0);
      end
      chk("pulse_t5", 16'(dut.start_pulse), 16'd1);
      serve_to_play(4, mk(1, 0, 0, 0, 0, 0, 0), mk(2, 0, 0, 0, 0, 1, 1), 0);
      chk("pulse_once", 16'(pulse_cnt - p0), 16'd1);
      start_btn = 1'b1;
   endtask

   initial begin
      int p0;
      reset      = 1'b1;
      start_btn  = 1'b1;
      miss_left  = 1'b0;
      miss_right = 1'b0;
      #8;
      chk("rst_hold", obs(), mk(0, 0, 0, 0, 0, 0, 0));
      #4 reset = 1'b0;
      repeat (10) begin
         tick();
         push("idle", mk(0, 0, 0, 0, 0, 0, 0));
      end

      p0 = pulse_cnt;
      start_btn = 1'b0;
      repeat (2) begin
         tick();
         push("glitch", mk(0, 0, 0, 0, 0, 0, 0));
      end
      start_btn = 1'b1;
      repeat (6) begin
         tick();
         push("glitch", mk(0, 0, 0, 0, 0, 0, 0));
      end
      chk("glitch_pulses", 16'(pulse_cnt - p0), 16'd0);

      start_match(mk(0, 0, 0, 0, 0, 0, 0));

      for (int k = 1; k <= 3; k++) begin
         miss_right = 1'b1;
         tick();
         miss_right = 1'b0;
         push("point_r", mk(3, 0, k, 0, 1, 0, 1));
         if (k < 3)
            serve_to_play(4, mk(1, 0, k, 0, 1, 0, 0), mk(2, 0, k, 0, 1, 1, 1), 0);
      end
      repeat (4) begin
         tick();
         push("over", mk(4, 1, 3, 0, 1, 0, 0));
      end

      start_match(mk(4, 1, 3, 0, 1, 0, 0));

      miss_right = 1'b1;
      tick();
      miss_right = 1'b0;
      push("point_r2", mk(3, 0, 1, 0, 1, 0, 1));
      serve_to_play(4, mk(1, 0, 1, 0, 1, 0, 0), mk(2, 0, 1, 0, 1, 1, 1), 0);

      miss_left  = 1'b1;
      miss_right = 1'b1;
      tick();
      miss_right = 1'b0;
      push("simul", mk(1, 0, 1, 0, 1, 0, 0));
      serve_to_play(3, mk(1, 0, 1, 0, 1, 0, 0), mk(2, 0, 1, 0, 1, 1, 1), 2);

      miss_left = 1'b1;
      tick();
      push("stuck_point", mk(3, 0, 1, 1, 0, 0, 1));
      serve_to_play(4, mk(1, 0, 1, 1, 0, 0, 0), mk(2, 0, 1, 1, 0, 1, 1), 4);

      miss_left = 1'b1;
      tick();
      miss_left = 1'b0;
      push("point_l", mk(3, 0, 1, 2, 0, 0, 1));
      serve_to_play(4, mk(1, 0, 1, 2, 0, 0, 0), mk(2, 0, 1, 2, 0, 1, 1), 0);

      @(negedge clk_1ms);
      #1 reset = 1'b1;
      #1;
      chk("rst_mid", obs(), mk(0, 0, 0, 0, 0, 0, 0));
      chk("rst_mid_s2", 16'(score2), 16'd0);
      #1 reset = 1'b0;
      repeat (3) begin
         tick();
         push("idle_after", mk(0, 0, 0, 0, 0, 0, 0));
      end

      @(negedge clk_1ms);
      #1;
      chk("sb_drained", 16'(sb.size()), 16'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/game_controller.md
# game_controller

Top-level Pong match sequencer running on the 1 ms game tick. It owns the match state: start, serve countdown, rally, point scoring and game over. It drives the active-low reset of the paddle block, gates ball motion and holds both scores. It sits between the player inputs and the paddle/ball datapath, and is the only source of the paddle reset.

## Interface

Parameters:
- WIN_SCORE, 7: points needed to win; legal range 1..15.
- SERVE_DELAY, 1000: ticks spent in SERVE before the ball is released; must be ≥1.
- DEBOUNCE, 20: consecutive low ticks of the synchronized start button required to register a press.

Ports:
- clk_1ms, in, 1: game tick clock.
- reset, in, 1: asynchronous, active-high; the only reset.
- start_btn, in, 1: raw start button, active-low, asynchronous to clk_1ms.
- miss_left, in, 1: one-tick pulse; ball passed the left paddle, so player 2 scores.
- miss_right, in, 1: one-tick pulse; ball passed the right paddle, so player 1 scores.
- paddle_rst_n, out, 1: active-low reset to the paddle block; low recentres both paddles.
- ball_en, out, 1: high only while the ball may move.
- serve_dir, out, 1: direction of the next serve; 0 = toward left player, 1 = toward right player.
- score1, out, 4: left player score.
- score2, out, 4: right player score.
- state, out, 3: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4.
- winner, out, 2: 00 none, 01 left player, 10 right player.

## Operation

- **Start input:** start_btn passes through a 2-FF synchronizer, then the debouncer. After DEBOUNCE consecutive low ticks, the debouncer emits a one-tick start_pulse. It does not re-arm until the synchronized input has been high for at least one tick.
- **IDLE**
  - Outputs: paddle_rst_n=0, ball_en=0, scores 0, winner 00.
  - Transition: start_pulse → SERVE.
- **SERVE**
  - Outputs: paddle_rst_n=0, ball_en=0.
  - The down-counter loads SERVE_DELAY−1 on entry and decrements each tick.
  - Transition: at 0 → PLAY.
- **PLAY**
  - Outputs: paddle_rst_n=1, ball_en=1.
  - miss_left alone: score2+1, serve_dir←0, → POINT.
  - miss_right alone: score1+1, serve_dir←1, → POINT.
  - Both misses in the same tick: no score change, serve_dir unchanged, → SERVE (replay).
- **POINT** (exactly one tick)
  - Outputs: paddle_rst_n=1, ball_en=0.
  - If score1==WIN_SCORE: winner←01, → OVER.
  - Else if score2==WIN_SCORE: winner←10, → OVER.
  - Else: → SERVE.
- **OVER**
  - Outputs: paddle_rst_n=0, ball_en=0; scores and winner held.
  - start_pulse: clear scores and winner, serve_dir←0, → SERVE.
- **Ignored inputs:** miss pulses outside PLAY; start_pulse in SERVE, PLAY and POINT.
- **Score arithmetic:** 4-bit unsigned. An increment cannot exceed WIN_SCORE because the match ends there, so no wrap is possible for legal parameters.
- **Reset:** async reset asserted at any time forces IDLE immediately.
  - Outputs go to: scores 0, winner 00, serve_dir 0, ball_en 0, paddle_rst_n 0.
  - Serve and debounce counters and the synchronizer are cleared; synchronizer FFs reset to 1 (released).

## Timing

- All outputs are registered or decoded from registered state; no combinational path from any input to any output.
- start_btn falling edge → start_pulse after 2 (sync) + DEBOUNCE ticks; state=SERVE one tick later.
- SERVE lasts exactly SERVE_DELAY ticks; ball_en rises on the tick state becomes PLAY.
- Miss sampled at edge N in PLAY:
  - At N: score and serve_dir update; state=POINT; ball_en=0.
  - At N+1: state=SERVE or OVER, with winner valid in OVER.
- A miss pulse held high for more than one tick scores once, because the FSM leaves PLAY on the first edge.

## Structure

- Shared game package holds:
  - the state encoding constants;
  - winner codes;
  - score width (4);
  - H_active=640 and V_active=480, shared with the paddle and ball blocks.
- One sub-module, btn_debounce: synchronizer plus debounce counter, parameter DEBOUNCE, output one-tick pulse. It is reused later for the paddle buttons.

## Test plan

Bench parameters: WIN_SCORE=3, SERVE_DELAY=4, DEBOUNCE=3.

- **Reset values:** reset pulse, then idle 10 ticks → state=0, paddle_rst_n=0, ball_en=0, score1=score2=0, winner=00.
- **Start and serve timing:** start_btn low 10 ticks → start_pulse exactly once, 5 ticks after the falling edge; SERVE lasts 4 ticks; ball_en=1 in PLAY. A 2-tick start glitch → stays IDLE.
- **Full match:** 3 miss_right pulses, each in PLAY → score1 1,2,3; serve_dir=1; state passes POINT for one tick each time; final state=4, winner=01. A further start press → scores 0, state=1.
- **Simultaneous miss:** miss_left and miss_right together in PLAY → scores unchanged, state=1 next tick, serve_dir unchanged. A miss_left during SERVE → ignored.
- **Reset mid-play:** reset asserted between clock edges during PLAY with score2=2 → immediate state=0, score2=0, ball_en=0, paddle_rst_n=0, with no clock edge required.
- **Stuck miss:** miss_left held high for 5 ticks in PLAY → score2 increments by exactly 1.
